// File: rtl/sram_block_mover_if.sv
// Command, status and Avalon-MM SRAM signals of the block mover, bundled as one port.
// The master modport is the engine's view; slave is the host/memory side.
interface sram_block_mover_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [ADDR_W-1:0]     cmd_src;
    logic [ADDR_W-1:0]     cmd_dst;
    logic [ADDR_W:0]       cmd_len;
    logic [DATA_W-1:0]     cmd_pattern;
    logic                  cmd_incr;
    logic                  busy;
    logic                  done;
    logic [ADDR_W:0]       err_count;
    logic [ADDR_W-1:0]     err_addr;
    logic                  err_seen;
    logic [ADDR_W-1:0]     m_address;
    logic [DATA_W/8-1:0]   m_byteenable;
    logic                  m_chipselect;
    logic                  m_write;
    logic [DATA_W-1:0]     m_writedata;
    logic [DATA_W-1:0]     m_readdata;
    logic                  m_clken;

    modport master (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_pattern, cmd_incr, m_readdata,
        output cmd_ready, busy, done, err_count, err_addr, err_seen,
               m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_pattern, cmd_incr, m_readdata,
        input  cmd_ready, busy, done, err_count, err_addr, err_seen,
               m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken
    );
endinterface

// File: rtl/sram_block_mover.sv
// Single-command SRAM engine: fill / copy / check a block using the SRAM's one-cycle read latency.
// Fill and check issue one access per cycle, copy alternates read/write; commands accepted only in IDLE.
module sram_block_mover #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    sram_block_mover_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_COPY_RD,
        S_COPY_WR,
        S_CHECK,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [1:0]      OP_FILL  = 2'd0;
    localparam logic [1:0]      OP_COPY  = 2'd1;
    localparam logic [1:0]      OP_RSVD  = 2'd3;
    localparam logic [ADDR_W:0] CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, dst_q;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W:0]     idx_q, idx_d;
    logic [DATA_W-1:0]   pat_q;
    logic                incr_q;
    logic [ADDR_W:0]     err_count_q;
    logic [ADDR_W-1:0]   err_addr_q;
    logic                err_seen_q;
    logic                cmp_vld_q, cmp_vld_d;
    logic [ADDR_W-1:0]   cmp_addr_q;
    logic [DATA_W-1:0]   cmp_exp_q;

    logic                accept;
    logic                last;
    logic [ADDR_W-1:0]   src_addr, dst_addr;
    logic [DATA_W-1:0]   pat_word;
    logic                cs, we;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;

    assign accept   = bus.cmd_valid && (state_q == S_IDLE);
    assign last     = (idx_q == len_q - 1'b1);
    assign src_addr = src_q + idx_q[ADDR_W-1:0];
    assign dst_addr = dst_q + idx_q[ADDR_W-1:0];
    assign pat_word = incr_q ? pat_q + DATA_W'(idx_q) : pat_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cmp_vld_d = 1'b0;
        cs        = 1'b0;
        we        = 1'b0;
        addr      = '0;
        wdata     = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    idx_d = '0;
                    if ((bus.cmd_len == '0) || (bus.cmd_op == OP_RSVD)) begin
                        state_d = S_DONE;
                    end else if (bus.cmd_op == OP_FILL) begin
                        state_d = S_FILL;
                    end else if (bus.cmd_op == OP_COPY) begin
                        state_d = S_COPY_RD;
                    end else begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_FILL: begin
                cs      = 1'b1;
                we      = 1'b1;
                addr    = dst_addr;
                wdata   = pat_word;
                idx_d   = idx_q + 1'b1;
                state_d = last ? S_DONE : S_FILL;
            end
            S_COPY_RD: begin
                cs      = 1'b1;
                addr    = src_addr;
                state_d = S_COPY_WR;
            end
            S_COPY_WR: begin
                // Read data arrives this cycle and is forwarded straight into the write.
                cs      = 1'b1;
                we      = 1'b1;
                addr    = dst_addr;
                wdata   = bus.m_readdata;
                idx_d   = idx_q + 1'b1;
                state_d = last ? S_DONE : S_COPY_RD;
            end
            S_CHECK: begin
                cs        = 1'b1;
                addr      = src_addr;
                cmp_vld_d = 1'b1;
                idx_d     = idx_q + 1'b1;
                state_d   = last ? S_DRAIN : S_CHECK;
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            pat_q       <= '0;
            incr_q      <= 1'b0;
            err_count_q <= '0;
            err_addr_q  <= '0;
            err_seen_q  <= 1'b0;
            cmp_vld_q   <= 1'b0;
            cmp_addr_q  <= '0;
            cmp_exp_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cmp_vld_q  <= cmp_vld_d;
            cmp_addr_q <= src_addr;
            cmp_exp_q  <= pat_word;
            if (accept) begin
                src_q       <= bus.cmd_src;
                dst_q       <= bus.cmd_dst;
                len_q       <= bus.cmd_len;
                pat_q       <= bus.cmd_pattern;
                incr_q      <= bus.cmd_incr;
                err_count_q <= '0;
                err_addr_q  <= '0;
                err_seen_q  <= 1'b0;
            end else if (cmp_vld_q && (bus.m_readdata != cmp_exp_q)) begin
                if (err_count_q != CNT_MAX) begin
                    err_count_q <= err_count_q + 1'b1;
                end
                if (!err_seen_q) begin
                    err_addr_q <= cmp_addr_q;
                    err_seen_q <= 1'b1;
                end
            end
        end
    end

    assign bus.cmd_ready    = (state_q == S_IDLE);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = (state_q == S_DONE);
    assign bus.err_count    = err_count_q;
    assign bus.err_addr     = err_addr_q;
    assign bus.err_seen     = err_seen_q;
    assign bus.m_address    = addr;
    assign bus.m_byteenable = '1;
    assign bus.m_chipselect = cs;
    assign bus.m_write      = we;
    assign bus.m_writedata  = wdata;
    assign bus.m_clken      = 1'b1;
endmodule

// File: tb/tb_sram_block_mover.sv
// Bench for sram_block_mover: SRAM model, per-command expected access trace and memory image,
// compared against the DUT every cycle, plus directed literal expectations.
module tb_sram_block_mover;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;
    localparam int MAXK  = 2 * DEPTH + 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    sram_block_mover_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    sram_block_mover #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM with one-cycle read latency; pokes let the bench seed contents while idle.
    logic [DW-1:0] mem [DEPTH];
    logic          poke_vld  = 1'b0;
    logic [AW-1:0] poke_addr = '0;
    logic [DW-1:0] poke_dat  = '0;
    always @(posedge clk) begin
        if (poke_vld) begin
            mem[poke_addr] = poke_dat;
        end else if (bus.m_chipselect) begin
            if (bus.m_write) mem[bus.m_address] = bus.m_writedata;
            else bus.m_readdata <= mem[bus.m_address];
        end
    end

    // Reference: expected memory, and the access expected k cycles after the accept cycle.
    logic [DW-1:0] gmem [DEPTH];
    int            t_acc = -1;
    int            dur   = 0;
    bit            e_cs   [MAXK];
    bit            e_we   [MAXK];
    logic [AW-1:0] e_addr [MAXK];
    logic [DW-1:0] e_wd   [MAXK];
    logic [AW:0]   m_cnt  = '0;
    logic [AW-1:0] m_ea   = '0;
    bit            m_seen = 1'b0;
    bit            chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        int k;
        k = (t_acc < 0) ? -1 : cyc - t_acc;
        if (poke_vld) gmem[poke_addr] = poke_dat;
        if (chk_en) begin
            check("byteenable", 64'(bus.m_byteenable), 64'hf);
            check("clken", 64'(bus.m_clken), 64'd1);
            if (k >= 1 && k <= dur) begin
                check("busy", 64'(bus.busy), 64'd1);
                check("cmd_ready", 64'(bus.cmd_ready), 64'd0);
                check("done", 64'(bus.done), 64'(k == dur));
                check("chipselect", 64'(bus.m_chipselect), 64'(e_cs[k]));
                check("write", 64'(bus.m_write), 64'(e_we[k]));
                if (e_cs[k]) check("address", 64'(bus.m_address), 64'(e_addr[k]));
                if (e_we[k]) begin
                    check("writedata", 64'(bus.m_writedata), 64'(e_wd[k]));
                    gmem[e_addr[k]] = e_wd[k];
                end
                if (k == dur) begin
                    check("err_count", 64'(bus.err_count), 64'(m_cnt));
                    check("err_addr", 64'(bus.err_addr), 64'(m_ea));
                    check("err_seen", 64'(bus.err_seen), 64'(m_seen));
                end
            end else begin
                check("idle_busy", 64'(bus.busy), 64'd0);
                check("idle_ready", 64'(bus.cmd_ready), 64'd1);
                check("idle_done", 64'(bus.done), 64'd0);
                check("idle_cs", 64'(bus.m_chipselect), 64'd0);
                check("idle_write", 64'(bus.m_write), 64'd0);
                if (k != 0) begin
                    check("hold_err_count", 64'(bus.err_count), 64'(m_cnt));
                    check("hold_err_addr", 64'(bus.err_addr), 64'(m_ea));
                    check("hold_err_seen", 64'(bus.err_seen), 64'(m_seen));
                end
            end
        end
    end

    task automatic wait_idle();
        int guard = 0;
        while (t_acc >= 0 && cyc <= t_acc + dur) begin
            @(posedge clk);
            #2;
            guard++;
            if (guard > 4000) begin
                n_fail++;
                $display("FAIL wait_idle: command did not complete within bound");
                break;
            end
        end
    endtask

    task automatic check_mem();
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== gmem[i]) bad++;
        check("mem_image", 64'(bad), 64'd0);
    endtask

    task automatic poke(input int a, input logic [DW-1:0] v);
        wait_idle();
        poke_addr = AW'(a % DEPTH);
        poke_dat  = v;
        poke_vld  = 1'b1;
        @(posedge clk);
        #2;
        poke_vld  = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input int src, input int dst, input int len,
                         input logic [DW-1:0] pat, input bit incr, input bit hold);
        logic [DW-1:0] scr [DEPTH];
        logic [DW-1:0] v;
        logic [AW:0]   cnt;
        logic [AW-1:0] ea;
        bit            seen;
        int            a, b, d;
        wait_idle();
        check_mem();
        scr  = gmem;
        cnt  = '0;
        ea   = '0;
        seen = 1'b0;
        if (len == 0 || op == 2'd3) d = 1;
        else if (op == 2'd0) d = len + 1;
        else if (op == 2'd1) d = 2 * len + 1;
        else d = len + 2;
        for (int k = 0; k <= d; k++) begin
            e_cs[k] = 1'b0; e_we[k] = 1'b0; e_addr[k] = '0; e_wd[k] = '0;
        end
        if (d > 1) begin
            for (int i = 0; i < len; i++) begin
                a = (src + i) % DEPTH;
                b = (dst + i) % DEPTH;
                v = incr ? pat + DW'(i) : pat;
                if (op == 2'd0) begin
                    e_cs[i+1] = 1'b1; e_we[i+1] = 1'b1; e_addr[i+1] = AW'(b); e_wd[i+1] = v;
                    scr[b] = v;
                end else if (op == 2'd1) begin
                    e_cs[2*i+1] = 1'b1; e_addr[2*i+1] = AW'(a);
                    e_cs[2*i+2] = 1'b1; e_we[2*i+2] = 1'b1; e_addr[2*i+2] = AW'(b);
                    e_wd[2*i+2] = scr[a];
                    scr[b] = scr[a];
                end else begin
                    e_cs[i+1] = 1'b1; e_addr[i+1] = AW'(a);
                    if (scr[a] !== v) begin
                        if (cnt != (AW+1)'(DEPTH)) cnt = cnt + 1'b1;
                        if (!seen) begin
                            seen = 1'b1;
                            ea   = AW'(a);
                        end
                    end
                end
            end
        end
        bus.cmd_op      = op;
        bus.cmd_src     = AW'(src % DEPTH);
        bus.cmd_dst     = AW'(dst % DEPTH);
        bus.cmd_len     = (AW+1)'(len);
        bus.cmd_pattern = pat;
        bus.cmd_incr    = incr;
        bus.cmd_valid   = 1'b1;
        m_cnt  = cnt;
        m_ea   = ea;
        m_seen = seen;
        dur    = d;
        t_acc  = cyc;
        @(posedge clk);
        #2;
        if (!hold) bus.cmd_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int src, dst, len;
        logic [1:0] op;
        logic [DW-1:0] pat;
        bit incr;
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = '0;
        bus.cmd_src     = '0;
        bus.cmd_dst     = '0;
        bus.cmd_len     = '0;
        bus.cmd_pattern = '0;
        bus.cmd_incr    = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_cs", 64'(bus.m_chipselect), 64'd0);
        check("rst_err_count", 64'(bus.err_count), 64'd0);
        check("rst_err_seen", 64'(bus.err_seen), 64'd0);
        reset  = 1'b0;
        chk_en = 1'b1;

        for (int i = 0; i < DEPTH; i++) poke(i, $urandom);

        // Incrementing fill at 100..103.
        issue(2'd0, 0, 100, 4, 32'hA5A5_0000, 1'b1, 1'b0);
        check("fill_dur", 64'(dur), 64'd5);
        wait_idle();
        check("fill_mem100", 64'(mem[100]), 64'hA5A5_0000);
        check("fill_mem103", 64'(mem[103]), 64'hA5A5_0003);

        // Copy wrapping past the top of memory.
        issue(2'd1, 100, 1022, 4, 32'h0, 1'b0, 1'b0);
        check("copy_dur", 64'(dur), 64'd9);
        wait_idle();
        check("copy_mem1022", 64'(mem[1022]), 64'hA5A5_0000);
        check("copy_mem0", 64'(mem[0]), 64'hA5A5_0002);
        check("copy_mem1", 64'(mem[1]), 64'hA5A5_0003);

        // Check with one corrupted word.
        poke(102, 32'hDEAD_BEEF);
        issue(2'd2, 100, 0, 4, 32'hA5A5_0000, 1'b1, 1'b0);
        check("check_dur", 64'(dur), 64'd6);
        wait_idle();
        check("chk1_err_count", 64'(bus.err_count), 64'd1);
        check("chk1_err_addr", 64'(bus.err_addr), 64'd102);
        check("chk1_err_seen", 64'(bus.err_seen), 64'd1);

        // Full-memory check over zeros with two bad words, then a zero-length fill.
        issue(2'd0, 0, 0, 1024, 32'h0, 1'b0, 1'b0);
        poke(5, 32'h1);
        poke(900, 32'h8000_0000);
        issue(2'd2, 0, 0, 1024, 32'h0, 1'b0, 1'b0);
        wait_idle();
        check("chk2_err_count", 64'(bus.err_count), 64'd2);
        check("chk2_err_addr", 64'(bus.err_addr), 64'd5);
        issue(2'd0, 0, 50, 0, 32'h1234, 1'b0, 1'b0);
        check("len0_dur", 64'(dur), 64'd1);
        wait_idle();
        check("len0_err_count", 64'(bus.err_count), 64'd0);
        check("len0_err_seen", 64'(bus.err_seen), 64'd0);

        // Reset during the second copy write cycle.
        issue(2'd1, 200, 600, 6, 32'h0, 1'b0, 1'b0);
        while (cyc < t_acc + 4) begin
            @(posedge clk);
            #2;
        end
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset  = 1'b0;
        t_acc  = -1;
        m_cnt  = '0;
        m_ea   = '0;
        m_seen = 1'b0;
        check("abort_ready", 64'(bus.cmd_ready), 64'd1);
        check("abort_cs", 64'(bus.m_chipselect), 64'd0);
        issue(2'd0, 0, 700, 3, 32'h55AA_0000, 1'b1, 1'b0);

        // cmd_valid held through a whole fill: the next accept lands on the first idle cycle.
        issue(2'd0, 0, 300, 4, 32'h0F0F_0000, 1'b1, 1'b1);
        issue(2'd0, 0, 300, 4, 32'h0F0F_0000, 1'b1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            op   = 2'($urandom_range(0, 3));
            src  = int'($urandom_range(0, DEPTH - 1));
            dst  = int'($urandom_range(0, DEPTH - 1));
            len  = int'($urandom_range(0, 40));
            pat  = $urandom;
            incr = 1'($urandom_range(0, 1));
            if (op == 2'd2 && $urandom_range(0, 1) == 1) begin
                issue(2'd0, 0, src, len, pat, incr, 1'b0);
                if (len > 0 && $urandom_range(0, 1) == 1)
                    poke(src + int'($urandom_range(0, len - 1)), $urandom);
            end
            issue(op, src, dst, len, pat, incr, 1'b0);
        end
        wait_idle();
        check_mem();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_block_mover.md
# sram_block_mover

Avalon-MM master engine for the 1024 x 32 single-port on-chip SRAM. It executes one command at a time: fill a block with a constant or incrementing pattern, copy a block, or check a block against a pattern. It sits beside the processor as a second master on the SRAM `s2` port and talks to the memory using its fixed one-cycle read latency. Typical uses are bulk initialisation, buffer moves and power-on memory test.

## Interface
Parameters:
- ADDR_W, 10, word address width; memory depth is 2^ADDR_W.
- DATA_W, 32, data width; byteenable width is DATA_W/8.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid & cmd_ready.
- cmd_op  in  2  0 = FILL, 1 = COPY, 2 = CHECK, 3 = reserved.
- cmd_src  in  ADDR_W  start address for COPY source and for CHECK.
- cmd_dst  in  ADDR_W  start address for FILL and COPY destination.
- cmd_len  in  ADDR_W+1  word count, 0..1024.
- cmd_pattern  in  DATA_W  FILL data or CHECK expected value.
- cmd_incr  in  1  if 1, the pattern for word i is cmd_pattern + i (mod 2^DATA_W).
- busy  out  1  high whenever not in IDLE.
- done  out  1  one-cycle pulse at command completion.
- err_count  out  ADDR_W+1  CHECK mismatch count.
- err_addr  out  ADDR_W  address of the first CHECK mismatch.
- err_seen  out  1  at least one CHECK mismatch occurred.
- m_address  out  ADDR_W  SRAM word address.
- m_byteenable  out  DATA_W/8  all ones.
- m_chipselect  out  1  access strobe.
- m_write  out  1  write qualifier; only ever asserted together with m_chipselect.
- m_writedata  out  DATA_W  write data.
- m_readdata  in  DATA_W  valid in the cycle after a read is issued.
- m_clken  out  1  constant 1.

## Operation
- States: IDLE, FILL, COPY_RD, COPY_WR, CHECK, DRAIN, DONE.
- On accept, the engine latches all cmd_* inputs, clears err_count, err_addr and err_seen, and resets the word index i to 0.
- If cmd_len = 0 or cmd_op = 3, the engine goes straight to DONE and issues no access.
- FILL: each cycle, write address cmd_dst + i with the pattern. Go to DONE after the last word.
- COPY: COPY_RD issues a read of cmd_src + i. COPY_WR writes cmd_dst + i with writedata driven combinationally from m_readdata. Then back to COPY_RD, or to DONE after the last word.
- CHECK: one read per cycle at cmd_src + i. Each read is compared one cycle later against the expected value for that word. After the last read, DRAIN performs the final compare, then DONE.
- On a mismatch: err_count increments (saturating at 1024). If err_seen was 0, err_addr takes the mismatching address and err_seen is set.
- Addresses wrap modulo 2^ADDR_W; for example, src 1020 with len 8 covers 1020..1023 then 0..3.
- COPY always runs in ascending order. Overlap with dst > src propagates the earlier data; this is the defined behaviour.
- DONE: done = 1 for one cycle, then IDLE. cmd_valid is ignored while busy.
- Error outputs hold their values until the next accept.
- Reset, including mid-command, forces IDLE on the next edge and aborts the transfer. All outputs go to 0 except cmd_ready = 1, m_byteenable = all ones and m_clken = 1. No access is issued in the cycle after reset.

## Timing
Accept occurs at the edge ending cycle T.
- FILL: writes in cycles T+1..T+len; done in T+len+1.
- COPY: reads in cycles T+1, T+3, …; writes in T+2, T+4, …; last write in T+2·len; done in T+2·len+1.
- CHECK: reads in cycles T+1..T+len; DRAIN in T+len+1; done in T+len+2. Error outputs are final in the done cycle.
- len = 0 or op = 3: done in T+1.
- cmd_ready returns high in the cycle after done, so back-to-back commands have exactly one IDLE cycle between them.
- When m_chipselect = 0: m_address and m_writedata are don't-care, and m_write = 0.

## Test plan
- FILL dst=100, len=4, pattern=0xA5A50000, incr=1 → writes 0xA5A50000..0xA5A50003 to addresses 100..103 in cycles T+1..T+4; done at T+5.
- COPY src=100, dst=1022, len=4 after the fill above → addresses 1022, 1023, 0, 1 hold 0xA5A50000..03; done at T+9; accesses strictly alternate read/write.
- CHECK src=100, len=4, pattern=0xA5A50000, incr=1 with address 102 corrupted → err_count=1, err_addr=102, err_seen=1 at done (T+6).
- CHECK len=1024, pattern=0, incr=0 over memory filled with zeros except addresses 5 and 900 → err_count=2, err_addr=5; then a FILL len=0 → done at T+1, no m_chipselect, error outputs cleared to 0.
- Reset asserted mid-COPY, during a COPY_WR cycle → next cycle is IDLE with cmd_ready=1 and m_chipselect=0; no further writes occur; a new command is accepted normally.
- cmd_valid held high through a whole FILL → exactly one command accepted per IDLE cycle; busy is 1 from T+1 through the done cycle.
